ip_ppi8255: RTL and testbench

- Parametrised 8255-compatible PPI (mode 0 only) on the MSX-50BUS I/O side.
- Provides three 8-bit ports (A, B, C) with programmable direction, a control register with mode-set and port-C bit set/reset (BSR), a configurable I/O base, and a configurable read-response latency.
- Replaces the fixed slot/keyboard PPI. The top level maps port A to the primary slot register, port B to the key matrix column and port C to row/motor/cas/caps/click.

---
 rtl/ip_ppi8255_pkg.sv | 32 +++
 rtl/ip_ppi8255_read_pipe.sv | 40 ++++
 rtl/ip_ppi8255.sv | 122 ++++++++++++
 tb/tb_ip_ppi8255.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_ppi8255_pkg.sv
// Shared constants and helpers for the 8255-compatible PPI (mode 0 only).
package ip_ppi8255_pkg;

  localparam int DATA_W = 8;

  // Register offsets within the four-byte I/O window
  typedef enum logic [1:0] {
    PORT_A    = 2'd0,
    PORT_B    = 2'd1,
    PORT_C    = 2'd2,
    PORT_CTRL = 2'd3
  } ppi_offset_e;

  // Control register bit positions (a 1 in a direction bit means input)
  localparam int CTRL_MODESET = 7;
  localparam int CTRL_A_DIR   = 4;
  localparam int CTRL_CU_DIR  = 3;
  localparam int CTRL_B_DIR   = 1;
  localparam int CTRL_CL_DIR  = 0;

  // Mode 0, every port an input
  localparam logic [7:0] CTRL_ALL_INPUT = 8'h9B;

  // Port C readback: each nibble shows the latch when it is an output, else the pins
  function automatic logic [7:0] port_c_view(input logic [7:0] latch,
                                             input logic [7:0] pins,
                                             input logic [1:0] oe);
    port_c_view[7:4] = oe[1] ? latch[7:4] : pins[7:4];
    port_c_view[3:0] = oe[0] ? latch[3:0] : pins[3:0];
  endfunction

endpackage

// File: rtl/ip_ppi8255_read_pipe.sv
// Fixed-depth shift pipeline that delays read data and its valid flag.
// A request entering at one edge appears on o_valid/o_data exactly DEPTH
// cycles later, for one cycle; consecutive requests stay separate.
module ip_ppi8255_read_pipe
  import ip_ppi8255_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];

  // Shift stages forward; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/ip_ppi8255.sv
// 8255-compatible PPI, mode 0 only, on the MSX-50BUS I/O side.
// Bus handshake: a read or write is a single-cycle strobe qualified by
// bus_io and an address hit; writes land at the next edge, and every read
// request is answered by exactly one bus_read_ready pulse READ_LATENCY
// cycles after its request edge (data is 00h whenever ready is low).
// READ_LATENCY must be in 1..4. Port pins are sampled without synchronisers.
module ip_ppi8255
  import ip_ppi8255_pkg::*;
#(
  parameter logic [7:0] IO_BASE      = 8'hA8,
  parameter int         READ_LATENCY = 1,
  parameter logic [7:0] CTRL_RESET   = CTRL_ALL_INPUT
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] bus_address,
  output logic        bus_io_cs,
  output logic        bus_memory_cs,
  output logic        bus_read_ready,
  output logic [7:0]  bus_read_data,
  input  logic [7:0]  bus_write_data,
  input  logic        bus_read,
  input  logic        bus_write,
  input  logic        bus_io,
  input  logic        bus_memory,
  input  logic [7:0]  port_a_in,
  input  logic [7:0]  port_b_in,
  input  logic [7:0]  port_c_in,
  output logic [7:0]  port_a_out,
  output logic [7:0]  port_b_out,
  output logic [7:0]  port_c_out,
  output logic        port_a_oe,
  output logic        port_b_oe,
  output logic [1:0]  port_c_oe
);

  logic [7:0]  r_ctrl;
  logic [7:0]  r_port_a;
  logic [7:0]  r_port_b;
  logic [7:0]  r_port_c;

  logic        w_hit;
  logic        w_wr;
  logic        w_rd;
  ppi_offset_e w_offset;
  logic [7:0]  w_rd_data;
  logic        w_pipe_valid;
  logic [7:0]  w_pipe_data;
  logic        w_unused;

  // Only the low address byte decodes; memory cycles are never claimed
  assign w_unused = ^{bus_memory, bus_address[15:8]};

  assign w_hit    = bus_io && (bus_address[7:2] == IO_BASE[7:2]);
  assign w_offset = ppi_offset_e'(bus_address[1:0]);
  assign w_wr     = w_hit && bus_write;
  assign w_rd     = w_hit && bus_read;

  assign port_a_oe    = ~r_ctrl[CTRL_A_DIR];
  assign port_b_oe    = ~r_ctrl[CTRL_B_DIR];
  assign port_c_oe[1] = ~r_ctrl[CTRL_CU_DIR];
  assign port_c_oe[0] = ~r_ctrl[CTRL_CL_DIR];

  assign port_a_out = r_port_a;
  assign port_b_out = r_port_b;
  assign port_c_out = r_port_c;

  assign bus_io_cs     = 1'b1;
  assign bus_memory_cs = 1'b0;

  // Register writes: port latches, mode set (clears all latches) and port C BSR
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_ctrl   <= CTRL_RESET;
      r_port_a <= 8'h00;
      r_port_b <= 8'h00;
      r_port_c <= 8'h00;
    end else if (w_wr) begin
      case (w_offset)
        PORT_A: r_port_a <= bus_write_data;
        PORT_B: r_port_b <= bus_write_data;
        PORT_C: r_port_c <= bus_write_data;
        default: begin
          if (bus_write_data[CTRL_MODESET]) begin
            r_ctrl   <= bus_write_data;
            r_port_a <= 8'h00;
            r_port_b <= 8'h00;
            r_port_c <= 8'h00;
          end else begin
            r_port_c[bus_write_data[3:1]] <= bus_write_data[0];
          end
        end
      endcase
    end
  end

  // Read-data selection from current (pre-write) state in the request cycle
  always_comb begin
    w_rd_data = 8'h00;
    case (w_offset)
      PORT_A:  w_rd_data = port_a_oe ? r_port_a : port_a_in;
      PORT_B:  w_rd_data = port_b_oe ? r_port_b : port_b_in;
      PORT_C:  w_rd_data = port_c_view(r_port_c, port_c_in, port_c_oe);
      default: w_rd_data = r_ctrl;
    endcase
  end

  ip_ppi8255_read_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .n_reset (n_reset),
    .i_valid (w_rd),
    .i_data  (w_rd_data),
    .o_valid (w_pipe_valid),
    .o_data  (w_pipe_data)
  );

  assign bus_read_ready = w_pipe_valid;
  assign bus_read_data  = w_pipe_valid ? w_pipe_data : 8'h00;

endmodule

// File: tb/tb_ip_ppi8255.sv
// Bench for ip_ppi8255: two instances (read latency 1 and 3) share one bus.
// Drivers push expected read data plus the cycle it must appear; a monitor
// per instance pops and compares whenever bus_read_ready is seen.
module tb_ip_ppi8255;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] bus_address;
  logic [7:0]  bus_write_data;
  logic        bus_read, bus_write, bus_io, bus_memory;
  logic [7:0]  port_a_in, port_b_in, port_c_in;

  logic        d1_io_cs, d1_mem_cs, d1_rdy, d1_a_oe, d1_b_oe;
  logic [7:0]  d1_rdata, d1_a_out, d1_b_out, d1_c_out;
  logic [1:0]  d1_c_oe;
  logic        d3_io_cs, d3_mem_cs, d3_rdy, d3_a_oe, d3_b_oe;
  logic [7:0]  d3_rdata, d3_a_out, d3_b_out, d3_c_out;
  logic [1:0]  d3_c_oe;

  logic [7:0]  exp_q1[$];
  logic [7:0]  exp_q3[$];
  int          cyc_q1[$];
  int          cyc_q3[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  ip_ppi8255 #(.IO_BASE(8'hA8), .READ_LATENCY(1), .CTRL_RESET(8'h9B)) u_dut1 (
    .clk(clk), .n_reset(n_reset), .bus_address(bus_address),
    .bus_io_cs(d1_io_cs), .bus_memory_cs(d1_mem_cs),
    .bus_read_ready(d1_rdy), .bus_read_data(d1_rdata),
    .bus_write_data(bus_write_data), .bus_read(bus_read), .bus_write(bus_write),
    .bus_io(bus_io), .bus_memory(bus_memory),
    .port_a_in(port_a_in), .port_b_in(port_b_in), .port_c_in(port_c_in),
    .port_a_out(d1_a_out), .port_b_out(d1_b_out), .port_c_out(d1_c_out),
    .port_a_oe(d1_a_oe), .port_b_oe(d1_b_oe), .port_c_oe(d1_c_oe)
  );

  ip_ppi8255 #(.IO_BASE(8'hA8), .READ_LATENCY(3), .CTRL_RESET(8'h9B)) u_dut3 (
    .clk(clk), .n_reset(n_reset), .bus_address(bus_address),
    .bus_io_cs(d3_io_cs), .bus_memory_cs(d3_mem_cs),
    .bus_read_ready(d3_rdy), .bus_read_data(d3_rdata),
    .bus_write_data(bus_write_data), .bus_read(bus_read), .bus_write(bus_write),
    .bus_io(bus_io), .bus_memory(bus_memory),
    .port_a_in(port_a_in), .port_b_in(port_b_in), .port_c_in(port_c_in),
    .port_a_out(d3_a_out), .port_b_out(d3_b_out), .port_c_out(d3_c_out),
    .port_a_oe(d3_a_oe), .port_b_oe(d3_b_oe), .port_c_oe(d3_c_oe)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_ports(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic a_oe, input logic b_oe, input logic [1:0] c_oe);
    chk("d1_a_out", {24'h0, d1_a_out}, {24'h0, a});
    chk("d1_b_out", {24'h0, d1_b_out}, {24'h0, b});
    chk("d1_c_out", {24'h0, d1_c_out}, {24'h0, c});
    chk("d1_a_oe", {31'h0, d1_a_oe}, {31'h0, a_oe});
    chk("d1_b_oe", {31'h0, d1_b_oe}, {31'h0, b_oe});
    chk("d1_c_oe", {30'h0, d1_c_oe}, {30'h0, c_oe});
    chk("d3_a_out", {24'h0, d3_a_out}, {24'h0, a});
    chk("d3_b_out", {24'h0, d3_b_out}, {24'h0, b});
    chk("d3_c_out", {24'h0, d3_c_out}, {24'h0, c});
    chk("d3_a_oe", {31'h0, d3_a_oe}, {31'h0, a_oe});
    chk("d3_b_oe", {31'h0, d3_b_oe}, {31'h0, b_oe});
    chk("d3_c_oe", {30'h0, d3_c_oe}, {30'h0, c_oe});
  endtask

  // One bus cycle, entered and left at a falling edge; queues expected reads
  task automatic acc(input logic [15:0] addr, input logic wr, input logic [7:0] wd,
                     input logic rd, input logic io, input bit exp1, input bit exp3,
                     input logic [7:0] ed);
    bus_address    = addr;
    bus_io         = io;
    bus_memory     = ~io;
    bus_write      = wr;
    bus_read       = rd;
    bus_write_data = wd;
    if (exp1) begin exp_q1.push_back(ed); cyc_q1.push_back(cyc + 1); end
    if (exp3) begin exp_q3.push_back(ed); cyc_q3.push_back(cyc + 3); end
    @(negedge clk);
    bus_write  = 1'b0;
    bus_read   = 1'b0;
    bus_io     = 1'b0;
    bus_memory = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] d);
    acc(addr, 1'b1, d, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [7:0] e);
    acc(addr, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, e);
  endtask

  // Scoreboard monitor for the latency-1 instance
  always @(negedge clk) begin
    if (mon_en) begin
      if (d1_rdy === 1'b1) begin
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rd1_unexpected: got ready with data %0h, expected no ready (cycle %0d)", d1_rdata, cyc);
        end else begin
          chk("rd1_data", {24'h0, d1_rdata}, {24'h0, exp_q1.pop_front()});
          chk("rd1_cycle", cyc, cyc_q1.pop_front());
        end
      end else begin
        chk("rd1_idle_data", {24'h0, d1_rdata}, 32'h0);
        if (cyc_q1.size() != 0 && cyc_q1[0] <= cyc) begin
          chk("rd1_missing_ready", {31'h0, d1_rdy}, 32'h1);
          void'(exp_q1.pop_front());
          void'(cyc_q1.pop_front());
        end
      end
    end
  end

  // Scoreboard monitor for the latency-3 instance
  always @(negedge clk) begin
    if (mon_en) begin
      if (d3_rdy === 1'b1) begin
        if (exp_q3.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rd3_unexpected: got ready with data %0h, expected no ready (cycle %0d)", d3_rdata, cyc);
        end else begin
          chk("rd3_data", {24'h0, d3_rdata}, {24'h0, exp_q3.pop_front()});
          chk("rd3_cycle", cyc, cyc_q3.pop_front());
        end
      end else begin
        chk("rd3_idle_data", {24'h0, d3_rdata}, 32'h0);
        if (cyc_q3.size() != 0 && cyc_q3[0] <= cyc) begin
          chk("rd3_missing_ready", {31'h0, d3_rdy}, 32'h1);
          void'(exp_q3.pop_front());
          void'(cyc_q3.pop_front());
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    n_reset        = 1'b0;
    bus_address    = 16'h0000;
    bus_write_data = 8'h00;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_io         = 1'b0;
    bus_memory     = 1'b0;
    port_a_in      = 8'h3C;
    port_b_in      = 8'hC3;
    port_c_in      = 8'hA5;

    // Reset and defaults
    repeat (3) @(negedge clk);
    mon_en  = 1'b1;
    n_reset = 1'b1;
    chk_ports(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("io_cs", {30'h0, d1_io_cs, d3_io_cs}, 32'h3);
    chk("mem_cs", {30'h0, d1_mem_cs, d3_mem_cs}, 32'h0);
    rd(16'h00AB, 8'h9B);

    // All outputs, port A latch readback
    wr(16'h00AB, 8'h80);
    wr(16'h00A8, 8'h5A);
    chk_ports(8'h5A, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11);
    rd(16'h00A8, 8'h5A);

    // A back to input: latch cleared, read returns pins
    wr(16'h00AB, 8'h90);
    chk_ports(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2'b11);
    rd(16'h00A8, 8'h3C);

    // C upper input, lower output: mixed readback
    wr(16'h00AB, 8'h88);
    wr(16'h00AA, 8'h0F);
    chk_ports(8'h00, 8'h00, 8'h0F, 1'b1, 1'b1, 2'b01);
    rd(16'h00AA, 8'hAF);

    // BSR: set bit7 (input nibble), set then clear bit5
    wr(16'h00AB, 8'h0F);
    chk("bsr_set7", {24'h0, d1_c_out}, 32'h8F);
    wr(16'h00AB, 8'h0B);
    chk("bsr_set5", {24'h0, d3_c_out}, 32'hAF);
    wr(16'h00AB, 8'h0A);
    chk_ports(8'h00, 8'h00, 8'h8F, 1'b1, 1'b1, 2'b01);
    rd(16'h00AB, 8'h88);
    rd(16'h00AA, 8'hAF);

    // Back-to-back reads A, B, C
    wr(16'h00A8, 8'h11);
    wr(16'h00A9, 8'h22);
    rd(16'h00A8, 8'h11);
    rd(16'h00A9, 8'h22);
    rd(16'h00AA, 8'hAF);

    // Same-cycle read+write returns old value; write behind a pending read
    acc(16'h00A8, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
    rd(16'h00A8, 8'h33);
    wr(16'h00A8, 8'h44);
    rd(16'h00A8, 8'h44);
    chk_ports(8'h44, 8'h22, 8'h8F, 1'b1, 1'b1, 2'b01);

    // Mode set clears every latch
    wr(16'h00AB, 8'h80);
    chk_ports(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11);

    // Non-hit and memory cycles are ignored; high address byte is ignored
    wr(16'h00A4, 8'h77);
    acc(16'h00A8, 1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    acc(16'h00A4, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    acc(16'h00A8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_ports(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 2'b11);
    wr(16'h12A8, 8'h55);
    chk("hi_addr_wr", {24'h0, d1_a_out}, 32'h55);
    rd(16'hFFA8, 8'h55);
    repeat (4) @(negedge clk);

    // Reset one cycle after a read: the latency-1 pulse is already out,
    // the latency-3 read is dropped
    acc(16'h00AB, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h80);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    chk_ports(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 2'b00);
    rd(16'h00AB, 8'h9B);
    rd(16'h00A9, 8'hC3);
    rd(16'h00A8, 8'h3C);
    rd(16'h00AA, 8'hA5);

    // Drain and report
    repeat (8) @(negedge clk);
    chk("q1_drained", exp_q1.size(), 32'h0);
    chk("q3_drained", exp_q3.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
